overlap_bus_master: RTL

//  Initiator side of the overlap/add shared-bus protocol. Takes one packed group of

---
 rtl/overlap_bus_master.sv | 112 +++++++++++
 1 files changed

// File: rtl/overlap_bus_master.sv
// Initiator for the overlap/add shared bus: drives the A and B groups with load strobes,
// turns the bus around, then reads back the per-lane sums from the overlap unit.
module overlap_bus_master #(
  parameter int wordLength      = 16,
  parameter int LANES           = 4,
  parameter int busSize         = wordLength * LANES,
  parameter int GROUPS_PER_HALF = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [busSize-1:0] in_a,
  input  logic [busSize-1:0] in_b,
  input  logic               in_valid,
  output logic               in_ready,
  inout  wire  [busSize-1:0] dataBus,
  output logic               ov_load,
  output logic               ov_action,
  output logic [busSize-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int CNT_W = (GROUPS_PER_HALF > 1) ? $clog2(GROUPS_PER_HALF) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS_PER_HALF - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRV1 = 3'd1;
  localparam logic [2:0] S_DRV2 = 3'd2;
  localparam logic [2:0] S_TURN = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]         r_state;
  logic [busSize-1:0] r_a;
  logic [busSize-1:0] r_b;
  logic               r_bus_oe;
  logic               r_ov_load;
  logic               r_ov_action;
  logic [busSize-1:0] r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic [CNT_W-1:0]   r_group_cnt;

  logic [busSize-1:0] w_bus_drv;

  // A goes out on the first load beat, B on the second.
  assign w_bus_drv = (r_state == S_DRV1) ? r_a : r_b;
  assign dataBus   = r_bus_oe ? w_bus_drv : {busSize{1'bz}};

  assign in_ready  = (r_state == S_IDLE);
  assign ov_load   = r_ov_load;
  assign ov_action = r_ov_action;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bus_oe    <= 1'b0;
      r_ov_load   <= 1'b0;
      r_ov_action <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_group_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a       <= in_a;
            r_b       <= in_b;
            r_bus_oe  <= 1'b1;
            r_ov_load <= 1'b1;
            r_state   <= S_DRV1;
          end
        end
        S_DRV1: r_state <= S_DRV2;
        S_DRV2: begin
          r_bus_oe  <= 1'b0;
          r_ov_load <= 1'b0;
          r_state   <= S_TURN;
        end
        // TURN leaves the bus floating for one cycle before the overlap unit drives it.
        S_TURN: begin
          r_ov_action <= 1'b1;
          r_state     <= S_READ;
        end
        S_READ: begin
          r_ov_action <= 1'b0;
          r_out_data  <= dataBus;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_group_cnt == LAST_CNT);
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_group_cnt <= (r_group_cnt == LAST_CNT) ? '0 : r_group_cnt + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
